dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_if.sv | 22 ++
 rtl/dmem_responder.sv | 153 +++++++++++++++
 tb/tb_dmem_responder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bundle between a requester and dmem_responder.
// The master modport is the requester side; the slave modport is the responder side.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-port word memory behind a valid/ready request and a fixed-latency response strobe.
// Misaligned-address error responses are enabled by defining DMEM_RESPONDER_MISALIGN_ERR_EN.
//
// state | meaning
// IDLE  | ready for a request; req_ready=1
// WAIT  | wait states; counter runs down to 0
// RESP  | one-cycle response strobe; always returns to IDLE
module dmem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH       = 64
) (
    input  logic               clock,
    input  logic               reset_,
    dmem_responder_if.slave    bus,
    output logic               busy
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [7:0]    addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   mem_q [DEPTH];

    logic          enter_resp;
    logic          cur_write;
    logic [7:0]    cur_addr;
    logic [31:0]   cur_wdata;
    logic [IW-1:0] cur_idx;
    logic          misalign;
    logic          mem_we;

    // With zero wait states the response is formed at the acceptance edge,
    // so the live request fields stand in for the not-yet-latched ones.
    always_comb begin
        if (state_q == IDLE) begin
            cur_write = bus.req_write;
            cur_addr  = bus.req_addr;
            cur_wdata = bus.req_wdata;
        end else begin
            cur_write = write_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
        cur_idx = IW'(32'(cur_addr[7:2]) % 32'(DEPTH));
    end

`ifdef DMEM_RESPONDER_MISALIGN_ERR_EN
    logic err_q, err_d;

    assign misalign     = (cur_addr[1:0] != 2'b00);
    assign err_d        = enter_resp & misalign;
    assign bus.resp_err = err_q;

    always_ff @(posedge clock) begin
        if (!reset_) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    logic unused_addr_lsb;

    assign misalign        = 1'b0;
    assign unused_addr_lsb = ^cur_addr[1:0];
    assign bus.resp_err    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_we  = enter_resp & cur_write & ~misalign;
        rdata_d = 32'd0;
        if (enter_resp && !cur_write && !misalign) begin
            rdata_d = mem_q[cur_idx];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 8'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage survives reset; a write landing on a reset edge is dropped.
    always_ff @(posedge clock) begin
        if (reset_ && mem_we) begin
            mem_q[cur_idx] <= cur_wdata;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (2 wait states, 0 wait states, DEPTH=4)
// share one clock and the request fields; each has its own valid and reset.
module tb_dmem_responder;

    localparam int WC [3] = '{2, 0, 2};

    logic        clk;
    logic [2:0]  rst;
    logic [2:0]  v;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;

    logic [2:0]  ready, valid, err, busy;
    logic [31:0] rdata [3];

    int total = 0;
    int bad   = 0;

    dmem_responder_if if0 ();
    dmem_responder_if if1 ();
    dmem_responder_if if2 ();

    assign if0.req_valid = v[0];
    assign if1.req_valid = v[1];
    assign if2.req_valid = v[2];
    assign if0.req_write = req_write;
    assign if1.req_write = req_write;
    assign if2.req_write = req_write;
    assign if0.req_addr  = req_addr;
    assign if1.req_addr  = req_addr;
    assign if2.req_addr  = req_addr;
    assign if0.req_wdata = req_wdata;
    assign if1.req_wdata = req_wdata;
    assign if2.req_wdata = req_wdata;

    assign ready = {if2.req_ready,  if1.req_ready,  if0.req_ready};
    assign valid = {if2.resp_valid, if1.resp_valid, if0.resp_valid};
    assign err   = {if2.resp_err,   if1.resp_err,   if0.resp_err};
    assign rdata[0] = if0.resp_rdata;
    assign rdata[1] = if1.resp_rdata;
    assign rdata[2] = if2.resp_rdata;

    dmem_responder #(.WAIT_CYCLES(2), .DEPTH(64)) u_w2 (
        .clock(clk), .reset_(rst[0]), .bus(if0.slave), .busy(busy[0]));
    dmem_responder #(.WAIT_CYCLES(0), .DEPTH(64)) u_w0 (
        .clock(clk), .reset_(rst[1]), .bus(if1.slave), .busy(busy[1]));
    dmem_responder #(.WAIT_CYCLES(2), .DEPTH(4)) u_d4 (
        .clock(clk), .reset_(rst[2]), .bus(if2.slave), .busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction on instance k, checking latency, payload and return to IDLE.
    task automatic xact(input int k, input logic wr, input logic [7:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input string tag);
        @(negedge clk);
        chk({tag, ".rdy"}, 32'(ready[k]), 32'd1);
        v[k]      = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        for (int i = 1; i <= WC[k] + 1; i++) begin
            @(negedge clk);
            if (i == 1) v[k] = 1'b0;
            chk({tag, ".vld"}, 32'(valid[k]), (i == WC[k] + 1) ? 32'd1 : 32'd0);
            chk({tag, ".busy"}, 32'(busy[k]), 32'd1);
        end
        chk({tag, ".rdata"}, rdata[k], exp_rd);
        chk({tag, ".err"}, 32'(err[k]), 32'(exp_err));
        @(negedge clk);
        chk({tag, ".vld_end"}, 32'(valid[k]), 32'd0);
        chk({tag, ".rdy_end"}, 32'(ready[k]), 32'd1);
        chk({tag, ".rdata_end"}, rdata[k], 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] a9;
        int         nresp;

        rst       = 3'b000;
        v         = 3'b000;
        req_write = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 32'h0;

        // reset
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst.vld",   32'(valid[k]), 32'd0);
            chk("rst.err",   32'(err[k]),   32'd0);
            chk("rst.rdata", rdata[k],      32'd0);
            chk("rst.busy",  32'(busy[k]),  32'd0);
        end
        rst = 3'b111;
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk("rst.rdy", 32'(ready[k]), 32'd1);

        // scenario 1: write then read with two wait states
        xact(0, 1'b1, 8'h10, 32'hDEADBEEF, 32'h0,        1'b0, "s1w");
        xact(0, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0, "s1r");

        // scenario 2: zero wait states, req_valid held high
        xact(1, 1'b1, 8'h00, 32'h01010101, 32'h0, 1'b0, "s2p0");
        xact(1, 1'b1, 8'h04, 32'h04040404, 32'h0, 1'b0, "s2p4");
        @(negedge clk);
        chk("s2.rdy0", 32'(ready[1]), 32'd1);
        v[1] = 1'b1; req_write = 1'b0; req_addr = 8'h00;
        @(negedge clk);
        chk("s2.rdy1", 32'(ready[1]), 32'd0);
        chk("s2.vld1", 32'(valid[1]), 32'd1);
        chk("s2.rd0",  rdata[1],      32'h01010101);
        req_addr = 8'h04;
        @(negedge clk);
        chk("s2.rdy2", 32'(ready[1]), 32'd1);
        chk("s2.vld2", 32'(valid[1]), 32'd0);
        @(negedge clk);
        chk("s2.rdy3", 32'(ready[1]), 32'd0);
        chk("s2.vld3", 32'(valid[1]), 32'd1);
        chk("s2.rd4",  rdata[1],      32'h04040404);
        v[1] = 1'b0;
        @(negedge clk);
        chk("s2.rdy4", 32'(ready[1]), 32'd1);
        chk("s2.vld4", 32'(valid[1]), 32'd0);

        // scenario 3: reset in the first WAIT cycle aborts a write
        xact(0, 1'b1, 8'h08, 32'hAAAA5555, 32'h0, 1'b0, "s3pre");
        @(negedge clk);
        v[0] = 1'b1; req_write = 1'b1; req_addr = 8'h08; req_wdata = 32'h12345678;
        @(negedge clk);
        chk("s3.busy_wait", 32'(busy[0]), 32'd1);
        v[0] = 1'b0; rst[0] = 1'b0;
        @(negedge clk);
        chk("s3.busy_rst", 32'(busy[0]),  32'd0);
        chk("s3.rdy_rst",  32'(ready[0]), 32'd1);
        chk("s3.vld_rst",  32'(valid[0]), 32'd0);
        rst[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s3.noresp", 32'(valid[0]), 32'd0);
        end
        xact(0, 1'b0, 8'h08, 32'h0, 32'hAAAA5555, 1'b0, "s3rd");

        // scenario 4: request inputs changing during WAIT are ignored
        xact(0, 1'b1, 8'h24, 32'h44444444, 32'h0, 1'b0, "s4pre");
        @(negedge clk);
        v[0] = 1'b1; req_write = 1'b1; req_addr = 8'h20; req_wdata = 32'h11112222;
        nresp = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) begin
                v[0] = 1'b0; req_addr = 8'h24; req_wdata = 32'h33333333;
            end else if (i == 2) begin
                v[0] = 1'b1;
            end else begin
                v[0] = 1'b0;
            end
            chk("s4.vld", 32'(valid[0]), (i == 3) ? 32'd1 : 32'd0);
            nresp += int'(valid[0]);
        end
        chk("s4.count", 32'(nresp), 32'd1);
        xact(0, 1'b0, 8'h20, 32'h0, 32'h11112222, 1'b0, "s4rd20");
        xact(0, 1'b0, 8'h24, 32'h0, 32'h44444444, 1'b0, "s4rd24");

        // scenario 5: misaligned write
        xact(0, 1'b1, 8'h0C, 32'h0C0C0C0C, 32'h0, 1'b0, "s5pre");
`ifdef DMEM_RESPONDER_MISALIGN_ERR_EN
        xact(0, 1'b1, 8'h0D, 32'h00000001, 32'h0,        1'b1, "s5w");
        xact(0, 1'b0, 8'h0C, 32'h0,        32'h0C0C0C0C, 1'b0, "s5rd");
`else
        xact(0, 1'b1, 8'h0D, 32'h00000001, 32'h0,        1'b0, "s5w");
        xact(0, 1'b0, 8'h0C, 32'h0,        32'h00000001, 1'b0, "s5rd");
`endif

        // scenario 6: address truncation and word-index wrap
        xact(0, 1'b1, 8'h00, 32'hCAFEF00D, 32'h0, 1'b0, "s6w0");
        a9 = 9'h100;
        xact(0, 1'b0, a9[7:0], 32'h0, 32'hCAFEF00D, 1'b0, "s6r100");
        xact(2, 1'b1, 8'h0C, 32'h5A5A0003, 32'h0,        1'b0, "s6w3");
        xact(2, 1'b0, 8'h1C, 32'h0,        32'h5A5A0003, 1'b0, "s6r1c");
        xact(2, 1'b1, 8'h14, 32'h00000077, 32'h0,        1'b0, "s6w14");
        xact(2, 1'b0, 8'h04, 32'h0,        32'h00000077, 1'b0, "s6r04");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
